// File: rtl/alu_pkg.sv
// Shared opcodes and width for the Y86 execute-stage ALU.
package alu_pkg;

  localparam int WIDTH = 64;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;
  localparam logic [1:0] ALU_XOR = 2'b11;

endpackage

// File: rtl/alu_64_if.sv
// Operand/opcode bundle into the ALU and registered result back out.
interface alu_64_if;
  import alu_pkg::*;

  logic [1:0]       control_signal;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] op_out;
  logic             overflow;

  modport master (
    output control_signal,
    output a,
    output b,
    input  op_out,
    input  overflow
  );

  modport slave (
    input  control_signal,
    input  a,
    input  b,
    output op_out,
    output overflow
  );

endinterface

// File: rtl/add_sub_64.sv
// Shared 64-bit adder/subtractor built from a ripple of 1-bit full adders.
module add_sub_64
  import alu_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum,
  output logic             ovf
);

  logic [WIDTH-1:0] bx;
  logic [WIDTH-1:0] g;
  logic [WIDTH-1:0] p;
  logic [WIDTH:0]   c;

  // sub inverts b and doubles as carry-in: a + ~b + 1
  always_comb begin
    bx   = b ^ {WIDTH{sub}};
    g    = a & bx;
    p    = a ^ bx;
    c    = '0;
    c[0] = sub;
    for (int i = 0; i < WIDTH; i++) begin
      c[i+1] = g[i] | (p[i] & c[i]);
    end
    sum = p ^ c[WIDTH-1:0];
    ovf = c[WIDTH-1] ^ c[WIDTH];
  end

endmodule

// File: rtl/alu_64.sv
// 64-bit ADD/SUB/AND/XOR ALU with registered result and signed overflow.
module alu_64
  import alu_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  alu_64_if.slave   bus
);

  logic [WIDTH-1:0] sum;
  logic             add_ovf;
  logic             is_sub;

  logic [WIDTH-1:0] op_out_d;
  logic [WIDTH-1:0] op_out_q;
  logic             ovf_d;
  logic             ovf_q;

  assign is_sub = (bus.control_signal == ALU_SUB);

  add_sub_64 u_add_sub (
    .a   (bus.a),
    .b   (bus.b),
    .sub (is_sub),
    .sum (sum),
    .ovf (add_ovf)
  );

  always_comb begin
    op_out_d = '0;
    ovf_d    = 1'b0;
    unique case (1'b1)
      (bus.control_signal == ALU_ADD),
      (bus.control_signal == ALU_SUB): begin
        op_out_d = sum;
        ovf_d    = add_ovf;
      end
      (bus.control_signal == ALU_AND): begin
        op_out_d = bus.a & bus.b;
      end
      (bus.control_signal == ALU_XOR): begin
        op_out_d = bus.a ^ bus.b;
      end
      default: begin
        op_out_d = '0;
        ovf_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_out_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      op_out_q <= op_out_d;
      ovf_q    <= ovf_d;
    end
  end

  assign bus.op_out   = op_out_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_alu_64.sv
// Self-checking bench for alu_64: directed table, reset sequence, random.
module tb_alu_64;
  import alu_pkg::*;

  logic clk;
  logic rst_n;

  alu_64_if bus ();

  alu_64 u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [1:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] r;
    logic        o;
  } vec_t;

  vec_t tbl [10];

  task automatic chk_r(input string nm,
                       input logic [63:0] act,
                       input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s op_out got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_o(input string nm,
                       input logic act,
                       input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s overflow got %b want %b", nm, act, exp);
    end
  endtask

  // Reference: exact signed arithmetic in 66 bits; overflow when
  // the truncated result no longer equals the true value.
  task automatic model(input logic [1:0] op,
                       input logic [63:0] a,
                       input logic [63:0] b,
                       output logic [63:0] r,
                       output logic o);
    logic signed [65:0] sa;
    logic signed [65:0] sb;
    logic signed [65:0] w;
    logic signed [65:0] rt;
    sa = $signed({{2{a[63]}}, a});
    sb = $signed({{2{b[63]}}, b});
    r  = '0;
    o  = 1'b0;
    case (op)
      2'b00, 2'b01: begin
        w  = (op == 2'b00) ? sa + sb : sa - sb;
        r  = w[63:0];
        rt = $signed({{2{r[63]}}, r});
        o  = (w != rt);
      end
      2'b10: r = a & b;
      default: r = a ^ b;
    endcase
  endtask

  task automatic drive(input logic [1:0] op,
                       input logic [63:0] a,
                       input logic [63:0] b);
    @(negedge clk);
    bus.control_signal = op;
    bus.a = a;
    bus.b = b;
    @(posedge clk);
    #1;
  endtask

  logic [63:0] er;
  logic        eo;
  logic [63:0] ra;
  logic [63:0] rb;
  logic [1:0]  rop;

  initial begin
    tbl[0] = '{ALU_ADD, -64'sd456, -64'sd154,
               64'hFFFFFFFFFFFFFD9E, 1'b0};
    tbl[1] = '{ALU_SUB, 64'd25620, -64'sd5264,
               64'd30884, 1'b0};
    tbl[2] = '{ALU_SUB, 64'd45871, 64'd154,
               64'd45717, 1'b0};
    tbl[3] = '{ALU_ADD, 64'hABCDABCDABCDABCD,
               64'hABCDABCDABCDABCD,
               64'h579B579B579B579A, 1'b1};
    tbl[4] = '{ALU_SUB, 64'h8000000000000000, 64'd1,
               64'h7FFFFFFFFFFFFFFF, 1'b1};
    tbl[5] = '{ALU_AND, 64'h5AA, 64'hFFF, 64'h5AA, 1'b0};
    tbl[6] = '{ALU_AND, 64'h55A, 64'h0, 64'h0, 1'b0};
    tbl[7] = '{ALU_XOR, 64'h42A, 64'hFFF, 64'hBD5, 1'b0};
    tbl[8] = '{ALU_XOR, 64'h32A, 64'hFFF, 64'hCD5, 1'b0};
    tbl[9] = '{ALU_SUB, 64'h0, 64'h8000000000000000,
               64'h8000000000000000, 1'b1};

    rst_n = 1'b0;
    bus.control_signal = ALU_ADD;
    bus.a = 64'd3;
    bus.b = 64'd4;
    #1;
    chk_r("reset_async", bus.op_out, 64'd0);
    chk_o("reset_async", bus.overflow, 1'b0);
    @(posedge clk);
    #1;
    chk_r("reset_hold", bus.op_out, 64'd0);
    chk_o("reset_hold", bus.overflow, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_r("first_edge", bus.op_out, 64'd7);
    chk_o("first_edge", bus.overflow, 1'b0);

    for (int i = 0; i < 10; i++) begin
      drive(tbl[i].op, tbl[i].a, tbl[i].b);
      chk_r($sformatf("tbl%0d", i), bus.op_out, tbl[i].r);
      chk_o($sformatf("tbl%0d", i), bus.overflow, tbl[i].o);
    end

    // Inputs changing mid-cycle must not reach the outputs
    drive(ALU_XOR, 64'hF0, 64'h0F);
    @(negedge clk);
    bus.a = 64'h1234;
    #2;
    chk_r("no_comb_path", bus.op_out, 64'hFF);

    // Reset pulse between edges with an overflowing ADD pending
    drive(ALU_ADD, 64'h7FFFFFFFFFFFFFFF, 64'h7FFFFFFFFFFFFFFF);
    chk_r("pre_rst", bus.op_out, 64'hFFFFFFFFFFFFFFFE);
    chk_o("pre_rst", bus.overflow, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_r("mid_rst", bus.op_out, 64'd0);
    chk_o("mid_rst", bus.overflow, 1'b0);
    @(posedge clk);
    #1;
    chk_r("rst_low_edge", bus.op_out, 64'd0);
    chk_o("rst_low_edge", bus.overflow, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_r("post_rst", bus.op_out, 64'hFFFFFFFFFFFFFFFE);
    chk_o("post_rst", bus.overflow, 1'b1);

    for (int i = 0; i < 300; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra = {$urandom, $urandom};
      rb = {$urandom, $urandom};
      if (i % 8 == 0) ra[63:62] = 2'b01;
      if (i % 8 == 1) ra[63:62] = 2'b10;
      if (i % 16 == 2) rb = ra;
      model(rop, ra, rb, er, eo);
      drive(rop, ra, rb);
      chk_r($sformatf("rnd%0d", i), bus.op_out, er);
      chk_o($sformatf("rnd%0d", i), bus.overflow, eo);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
